// File: rtl/ps2_scan_sequencer.sv
// Assembles PS/2 receiver bytes into key events (extended/break prefixes),
// presents one event at a time over valid/ready and gates the receiver meanwhile.
module ps2_scan_sequencer #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TW             = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] dout,
    output logic       rx_en,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       seq_error,
    output logic [1:0] dbg_state
);

    // Handshake: an event transfers on a rising edge where key_valid and
    // key_ready are both 1; key_valid never depends on key_ready, and the
    // event fields stay constant while key_valid is high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        BRK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          ext_r;
    logic          brk_r;
    logic [7:0]    code_r;
    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ext_r     <= 1'b0;
            brk_r     <= 1'b0;
            code_r    <= 8'h00;
            cnt       <= '0;
            seq_error <= 1'b0;
        end else begin
            seq_error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_done_tick) begin
                        case (dout)
                            8'hE0: begin
                                ext_r <= 1'b1;
                                state <= EXT;
                            end
                            8'hF0: begin
                                brk_r <= 1'b1;
                                state <= BRK;
                            end
                            8'hAA, 8'hFA, 8'hEE: ;
                            8'h00, 8'hFF: seq_error <= 1'b1;
                            default: begin
                                code_r <= dout;
                                state  <= HOLD;
                            end
                        endcase
                    end
                end
                EXT: begin
                    if (rx_done_tick) begin
                        cnt <= '0;
                        case (dout)
                            8'hF0: begin
                                brk_r <= 1'b1;
                                state <= BRK;
                            end
                            8'hE0, 8'h00, 8'hFF: begin
                                seq_error <= 1'b1;
                                ext_r     <= 1'b0;
                                brk_r     <= 1'b0;
                                state     <= IDLE;
                            end
                            default: begin
                                code_r <= dout;
                                state  <= HOLD;
                            end
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        seq_error <= 1'b1;
                        ext_r     <= 1'b0;
                        brk_r     <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                BRK: begin
                    if (rx_done_tick) begin
                        cnt <= '0;
                        case (dout)
                            8'hE0, 8'hF0, 8'h00, 8'hFF: begin
                                seq_error <= 1'b1;
                                ext_r     <= 1'b0;
                                brk_r     <= 1'b0;
                                state     <= IDLE;
                            end
                            default: begin
                                code_r <= dout;
                                state  <= HOLD;
                            end
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        seq_error <= 1'b1;
                        ext_r     <= 1'b0;
                        brk_r     <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                HOLD: begin
                    cnt <= '0;
                    // A frame already in flight when rx_en dropped is lost.
                    if (rx_done_tick) begin
                        seq_error <= 1'b1;
                    end
                    if (key_ready) begin
                        ext_r <= 1'b0;
                        brk_r <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign key_valid = (state == HOLD);
    assign rx_en     = (state != HOLD);
    assign key_code  = code_r;
    assign key_ext   = ext_r;
    assign key_break = brk_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: prefix-list reference model, per-cycle compare,
// event scoreboard, directed scenarios and randomized byte streams.
module tb_ps2_scan_sequencer;

    localparam int T  = 20;
    localparam int TW = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       rx_en;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       seq_error;
    logic [1:0] dbg_state;

    ps2_scan_sequencer #(.TIMEOUT_CYCLES(T), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .rx_en        (rx_en),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .seq_error    (seq_error),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    int errs_seen;
    int valids_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of prefix bytes seen since the last event,
    // a quiet-cycle counter and the pending event.
    logic [7:0] pre_q[$];
    logic [9:0] exp_q[$];
    int         quiet   = 0;
    bit         m_pend  = 0;
    logic [7:0] m_code  = 8'h00;
    bit         m_ext   = 0;
    bit         m_brk   = 0;
    bit         exp_err = 0;

    function automatic bit q_has(input logic [7:0] v);
        foreach (pre_q[i]) if (pre_q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit was_pend;
        bit he0;
        bit hf0;
        was_pend = m_pend;
        exp_err  = 0;
        if (rst) begin
            pre_q.delete();
            exp_q.delete();
            quiet  = 0;
            m_pend = 0;
            m_code = 8'h00;
        end else begin
            if (rx_done_tick) begin
                quiet = 0;
                he0 = q_has(8'hE0);
                hf0 = q_has(8'hF0);
                if (was_pend) begin
                    exp_err = 1;
                end else if (pre_q.size() == 0 &&
                             (dout == 8'hAA || dout == 8'hFA || dout == 8'hEE)) begin
                    exp_err = 0;
                end else if (dout == 8'h00 || dout == 8'hFF) begin
                    exp_err = 1;
                    pre_q.delete();
                end else if (dout == 8'hE0) begin
                    if (pre_q.size() == 0) pre_q.push_back(dout);
                    else begin exp_err = 1; pre_q.delete(); end
                end else if (dout == 8'hF0) begin
                    if (hf0) begin exp_err = 1; pre_q.delete(); end
                    else pre_q.push_back(dout);
                end else begin
                    m_pend = 1;
                    m_code = dout;
                    m_ext  = he0;
                    m_brk  = hf0;
                    exp_q.push_back({he0, hf0, dout});
                    pre_q.delete();
                end
            end else if (pre_q.size() != 0) begin
                quiet++;
                if (quiet == T) begin
                    exp_err = 1;
                    quiet   = 0;
                    pre_q.delete();
                end
            end
            if (was_pend && key_ready) m_pend = 0;
        end
    end

    // Per-cycle compare plus event scoreboard.
    always @(negedge clk) begin
        logic [9:0] ev;
        if (started) begin
            chk("key_valid", key_valid, m_pend);
            chk("rx_en", rx_en, !m_pend);
            chk("seq_error", seq_error, exp_err);
            chk("key_code", key_code, m_code);
            chk("key_ext", key_ext, m_pend ? m_ext : q_has(8'hE0));
            chk("key_break", key_break, m_pend ? m_brk : q_has(8'hF0));
            if (key_valid && key_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("event_unexpected", 1, 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event", {key_ext, key_break, key_code}, ev);
                end
            end
        end
    end

    // Drive one cycle of inputs and sample outputs mid-cycle.
    task automatic step(input logic r, input logic t, input logic [7:0] b, input logic k);
        @(posedge clk);
        #1;
        rst = r; rx_done_tick = t; dout = b; key_ready = k;
        @(negedge clk);
        if (seq_error === 1'b1) errs_seen++;
        if (key_valid === 1'b1) valids_seen++;
    endtask

    task automatic release_event();
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
    endtask

    logic [7:0] pick;

    initial begin
        int n;
        rst = 1; rx_done_tick = 0; dout = 8'h00; key_ready = 0;
        errs_seen = 0; valids_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        started = 1;
        @(negedge clk);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_rx_en", rx_en, 1);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_flags", {key_ext, key_break, seq_error}, 3'b000);
        step(0, 0, 8'h00, 0);

        // Make code held under backpressure, then transferred.
        step(0, 1, 8'h1C, 0);
        step(0, 0, 8'h00, 0);
        chk("make_valid", key_valid, 1);
        chk("make_rx_en", rx_en, 0);
        chk("make_fields", {key_ext, key_break, key_code}, {2'b00, 8'h1C});
        repeat (3) step(0, 0, 8'h00, 0);
        chk("make_hold", {key_valid, key_code}, {1'b1, 8'h1C});
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        chk("make_released", {key_valid, rx_en}, 2'b01);

        // Extended break.
        errs_seen = 0;
        step(0, 1, 8'hE0, 0);
        step(0, 1, 8'hF0, 0);
        step(0, 1, 8'h75, 0);
        step(0, 0, 8'h00, 0);
        chk("extbrk_fields", {key_valid, key_ext, key_break, key_code}, {3'b111, 8'h75});
        release_event();
        chk("extbrk_no_err", errs_seen, 0);

        // Timeout after a lone break prefix.
        step(0, 1, 8'hF0, 0);
        n = 0;
        for (int i = 1; i <= 3 * T; i++) begin
            step(0, 0, 8'h00, 0);
            if (seq_error === 1'b1) begin n = i; break; end
        end
        chk("timeout_latency", n, T + 1);
        step(0, 1, 8'h1C, 0);
        step(0, 0, 8'h00, 0);
        chk("after_timeout", {key_valid, key_break, key_code}, {2'b10, 8'h1C});
        release_event();

        // Tick in the last allowed cycle beats the timeout.
        errs_seen = 0;
        step(0, 1, 8'hF0, 0);
        repeat (T - 1) step(0, 0, 8'h00, 0);
        step(0, 1, 8'h1C, 0);
        step(0, 0, 8'h00, 0);
        chk("late_tick", {key_valid, key_break, key_code}, {2'b11, 8'h1C});
        release_event();
        chk("late_tick_no_err", errs_seen, 0);

        // Protocol errors and status bytes.
        errs_seen = 0; valids_seen = 0;
        step(0, 1, 8'hE0, 0); step(0, 1, 8'hE0, 0);
        repeat (2) step(0, 0, 8'h00, 0);
        chk("err_e0e0", errs_seen, 1);
        step(0, 1, 8'hF0, 0); step(0, 1, 8'hF0, 0);
        repeat (2) step(0, 0, 8'h00, 0);
        chk("err_f0f0", errs_seen, 2);
        step(0, 1, 8'h00, 0);
        repeat (2) step(0, 0, 8'h00, 0);
        chk("err_overrun", errs_seen, 3);
        step(0, 1, 8'hAA, 0); step(0, 1, 8'hFA, 0);
        repeat (2) step(0, 0, 8'h00, 0);
        chk("status_bytes", {errs_seen, valids_seen}, {32'd3, 32'd0});

        // Byte arriving while an event is pending is dropped.
        step(0, 1, 8'h1C, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h29, 0);
        step(0, 0, 8'h00, 0);
        chk("drop_err", {seq_error, key_valid, key_code}, {2'b11, 8'h1C});
        release_event();
        step(0, 1, 8'h29, 0);
        step(0, 0, 8'h00, 0);
        chk("after_drop", {key_valid, key_code}, {1'b1, 8'h29});
        release_event();

        // Reset mid-sequence.
        errs_seen = 0;
        step(0, 1, 8'hE0, 0);
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h1C, 0);
        step(0, 0, 8'h00, 0);
        chk("rst_mid", {key_valid, key_ext, key_code}, {2'b10, 8'h1C});
        release_event();
        chk("rst_mid_no_err", errs_seen, 0);

        // Randomized byte streams with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 11))
                0: pick = 8'hE0;
                1: pick = 8'hF0;
                2: pick = 8'hAA;
                3: pick = 8'hFA;
                4: pick = 8'hEE;
                5: pick = 8'h00;
                6: pick = 8'hFF;
                default: pick = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                repeat (T + 3) step(0, 0, 8'h00, 1'($urandom_range(0, 1)));
            end
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 35, pick,
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
